// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl
//   Central sequencer for the stopwatch datapath. Turns debounced one-cycle
//   button pulses into the counter enable code and a clear pulse, keeps a
//   small lap-time buffer filled from sec_count, and selects whether the
//   display shows the live count or a stored lap.
//
// Ports
//   clk           system clock, all state on rising edge
//   hard_reset    asynchronous active-low reset
//   start_p       start/stop pulse
//   soft_reset_p  soft-reset pulse (clears laps, pulses clr)
//   lap_p         lap pulse (stores sec_count while running)
//   recall_p      recall/next pulse (browse stored laps while stopped)
//   sec_count     live count from sec_counter
//   en            counter command: 00 idle, 01 count, 10 hold
//   clr           one-cycle clear pulse to counter and timer
//   disp_sel      0 = live count shown, 1 = lap entry shown
//   disp_count    registered display value
//   lap_idx       lap entry shown (valid when disp_sel=1), 0 = oldest
//   lap_cnt       number of stored laps
//   lap_full      lap_cnt == LAP_DEPTH
//
// Build option
//   STOPWATCH_LAP_OVERWRITE_EN: when defined, a lap on a full buffer
//   overwrites the oldest entry; otherwise it is ignored.
//
// state  | meaning
// IDLE   | counter held at zero, waiting for start
// RUN    | counting, lap pulses store entries
// STOP   | counting paused, live value displayed
// RECALL | counting paused, stored lap displayed

module stopwatch_ctrl #(
  parameter int CNT_W     = 19,
  parameter int LAP_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         hard_reset,
  input  logic                         start_p,
  input  logic                         soft_reset_p,
  input  logic                         lap_p,
  input  logic                         recall_p,
  input  logic [CNT_W-1:0]             sec_count,
  output logic [1:0]                   en,
  output logic                         clr,
  output logic                         disp_sel,
  output logic [CNT_W-1:0]             disp_count,
  output logic [$clog2(LAP_DEPTH)-1:0] lap_idx,
  output logic [$clog2(LAP_DEPTH):0]   lap_cnt,
  output logic                         lap_full
);

  localparam int IW = $clog2(LAP_DEPTH);
  localparam int CW = IW + 1;

`ifdef STOPWATCH_LAP_OVERWRITE_EN
  localparam logic OVERWRITE = 1'b1;
`else
  localparam logic OVERWRITE = 1'b0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_STOP, S_RECALL} state_t;

  state_t            state;
  logic [IW-1:0]     wr_ptr;
  logic [CNT_W-1:0]  lap_mem [LAP_DEPTH];

  logic              lp;
  logic              rc;
  logic              lap_wr;
  logic [IW-1:0]     oldest;
  logic [IW-1:0]     idx_next;
  logic [IW-1:0]     rd_next;

  // Priority decode: soft reset > start > lap > recall; losers are dropped.
  // Once the buffer is full the write pointer sits on the oldest entry,
  // so the oldest-read base is either 0 or wr_ptr.
  always_comb begin
    lp       = lap_p & ~soft_reset_p & ~start_p;
    rc       = recall_p & ~soft_reset_p & ~start_p & ~lap_p;
    lap_wr   = (state == S_RUN) & lp & (~lap_full | OVERWRITE);
    oldest   = lap_full ? wr_ptr : '0;
    idx_next = ({1'b0, lap_idx} == lap_cnt - 1'b1) ? '0 : lap_idx + 1'b1;
    rd_next  = oldest + idx_next;
  end

  always_ff @(posedge clk) begin
    if (lap_wr) lap_mem[wr_ptr] <= sec_count;
  end

  always_ff @(posedge clk or negedge hard_reset) begin
    if (!hard_reset) begin
      state      <= S_IDLE;
      en         <= 2'b00;
      clr        <= 1'b0;
      disp_sel   <= 1'b0;
      disp_count <= '0;
      lap_idx    <= '0;
      lap_cnt    <= '0;
      lap_full   <= 1'b0;
      wr_ptr     <= '0;
    end else begin
      clr        <= 1'b0;
      disp_count <= sec_count;
      if (soft_reset_p) begin
        state    <= S_IDLE;
        en       <= 2'b00;
        clr      <= 1'b1;
        disp_sel <= 1'b0;
        lap_idx  <= '0;
        lap_cnt  <= '0;
        lap_full <= 1'b0;
        wr_ptr   <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start_p) begin
              state <= S_RUN;
              en    <= 2'b01;
            end
          end
          S_RUN: begin
            if (start_p) begin
              state <= S_STOP;
              en    <= 2'b10;
            end else if (lap_wr) begin
              wr_ptr <= wr_ptr + 1'b1;
              if (!lap_full) begin
                lap_cnt  <= lap_cnt + 1'b1;
                lap_full <= (lap_cnt == CW'(LAP_DEPTH - 1));
              end
            end
          end
          S_STOP: begin
            if (start_p) begin
              state <= S_RUN;
              en    <= 2'b01;
            end else if (rc && (lap_cnt != '0)) begin
              state      <= S_RECALL;
              disp_sel   <= 1'b1;
              lap_idx    <= '0;
              disp_count <= lap_mem[oldest];
            end
          end
          S_RECALL: begin
            if (start_p) begin
              state    <= S_STOP;
              disp_sel <= 1'b0;
            end else if (rc) begin
              lap_idx    <= idx_next;
              disp_count <= lap_mem[rd_next];
            end else begin
              disp_count <= disp_count;
            end
          end
          default: begin
            state <= S_IDLE;
            en    <= 2'b00;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl
//   Self-checking bench for stopwatch_ctrl. A driver issues one pulse vector
//   per cycle and pushes the reference model's expected outputs into a
//   queue; a monitor pops and compares one entry after every rising edge.
//   The reference keeps laps as an oldest-first queue.

module tb_stopwatch_ctrl;

  localparam int CNT_W = 19;
  localparam int D     = 4;
  localparam int IW    = 2;

`ifdef STOPWATCH_LAP_OVERWRITE_EN
  localparam bit OVR = 1'b1;
`else
  localparam bit OVR = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             hard_reset = 1'b0;
  logic             start_p = 1'b0;
  logic             soft_reset_p = 1'b0;
  logic             lap_p = 1'b0;
  logic             recall_p = 1'b0;
  logic [CNT_W-1:0] sec_count = '0;
  logic [1:0]       en;
  logic             clr;
  logic             disp_sel;
  logic [CNT_W-1:0] disp_count;
  logic [IW-1:0]    lap_idx;
  logic [IW:0]      lap_cnt;
  logic             lap_full;

  always #5 clk = ~clk;

  stopwatch_ctrl #(.CNT_W(CNT_W), .LAP_DEPTH(D)) dut (
    .clk(clk), .hard_reset(hard_reset), .start_p(start_p),
    .soft_reset_p(soft_reset_p), .lap_p(lap_p), .recall_p(recall_p),
    .sec_count(sec_count), .en(en), .clr(clr), .disp_sel(disp_sel),
    .disp_count(disp_count), .lap_idx(lap_idx), .lap_cnt(lap_cnt),
    .lap_full(lap_full)
  );

  typedef struct packed {
    logic [1:0]       en;
    logic             clr;
    logic             disp_sel;
    logic [CNT_W-1:0] disp_count;
    logic [IW-1:0]    lap_idx;
    logic [IW:0]      lap_cnt;
    logic             lap_full;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   passed = 0;

  // reference model
  localparam int M_IDLE = 0, M_RUN = 1, M_STOP = 2, M_RECALL = 3;
  int               m_mode;
  int               m_idx;
  bit               m_sel;
  logic [CNT_W-1:0] m_laps[$];

  task automatic model_reset();
    m_mode = M_IDLE;
    m_idx  = 0;
    m_sel  = 1'b0;
    m_laps.delete();
  endtask

  task automatic model_step(input bit sr, st, lp, rc, input logic [CNT_W-1:0] sc,
                            output exp_t e);
    bit c;
    c = 1'b0;
    if (sr) begin
      model_reset();
      c = 1'b1;
    end else if (st) begin
      case (m_mode)
        M_IDLE:   m_mode = M_RUN;
        M_RUN:    m_mode = M_STOP;
        M_STOP:   m_mode = M_RUN;
        default: begin m_mode = M_STOP; m_sel = 1'b0; end
      endcase
    end else if (lp) begin
      if (m_mode == M_RUN) begin
        if (m_laps.size() < D) m_laps.push_back(sc);
        else if (OVR) begin
          void'(m_laps.pop_front());
          m_laps.push_back(sc);
        end
      end
    end else if (rc) begin
      if (m_mode == M_STOP && m_laps.size() > 0) begin
        m_mode = M_RECALL;
        m_sel  = 1'b1;
        m_idx  = 0;
      end else if (m_mode == M_RECALL) begin
        m_idx = (m_idx + 1) % m_laps.size();
      end
    end
    e.en         = (m_mode == M_IDLE) ? 2'b00 : (m_mode == M_RUN) ? 2'b01 : 2'b10;
    e.clr        = c;
    e.disp_sel   = m_sel;
    e.disp_count = m_sel ? m_laps[m_idx] : sc;
    e.lap_idx    = IW'(m_idx);
    e.lap_cnt    = (IW+1)'(m_laps.size());
    e.lap_full   = (m_laps.size() == D);
  endtask

  task automatic check_outs(input string name, input exp_t e, input bit chk_idx);
    checks++;
    if (en === e.en && clr === e.clr && disp_sel === e.disp_sel &&
        disp_count === e.disp_count && lap_cnt === e.lap_cnt &&
        lap_full === e.lap_full && (!chk_idx || lap_idx === e.lap_idx))
      passed++;
    else
      $display("FAIL %s t=%0t: got en=%b clr=%b sel=%b disp=%0d idx=%0d cnt=%0d full=%b; want en=%b clr=%b sel=%b disp=%0d idx=%0d cnt=%0d full=%b",
               name, $time, en, clr, disp_sel, disp_count, lap_idx, lap_cnt, lap_full,
               e.en, e.clr, e.disp_sel, e.disp_count, e.lap_idx, e.lap_cnt, e.lap_full);
  endtask

  // monitor: outputs are settled one time unit after each rising edge
  always @(posedge clk) begin
    #1;
    if (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      check_outs("scoreboard", e, e.disp_sel);
    end
  end

  task automatic drive(input bit sr, st, lp, rc, input logic [CNT_W-1:0] sc);
    exp_t e;
    @(negedge clk);
    soft_reset_p = sr;
    start_p      = st;
    lap_p        = lp;
    recall_p     = rc;
    sec_count    = sc;
    model_step(sr, st, lp, rc, sc, e);
    sb_q.push_back(e);
  endtask

  task automatic idle(input logic [CNT_W-1:0] sc);
    drive(1'b0, 1'b0, 1'b0, 1'b0, sc);
  endtask

  exp_t reset_e;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_e = '0;
    model_reset();
    #3;
    check_outs("reset", reset_e, 1'b1);
    @(negedge clk);
    hard_reset = 1'b1;

    // start / stop / resume
    drive(0, 1, 0, 0, 100);
    idle(101);
    drive(0, 1, 0, 0, 102);
    idle(102);
    drive(0, 1, 0, 0, 103);
    idle(104);

    // three laps, stop, recall with wrap
    drive(0, 0, 1, 0, 5);
    idle(7);
    drive(0, 0, 1, 0, 9);
    drive(0, 0, 1, 0, 14);
    drive(0, 1, 0, 0, 15);
    drive(0, 0, 0, 1, 15);
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 1, 16);
    idle(17);

    // leave recall, resume, start+lap together, soft+start together
    drive(0, 1, 0, 0, 18);
    drive(0, 1, 0, 0, 19);
    drive(0, 1, 1, 0, 20);
    drive(1, 1, 0, 0, 21);
    idle(22);

    // overflow the lap buffer
    drive(0, 1, 0, 0, 0);
    for (int v = 1; v <= 5; v++) drive(0, 0, 1, 0, v);
    drive(0, 1, 0, 0, 6);
    for (int i = 0; i < 5; i++) drive(0, 0, 0, 1, 6);

    // recall ignored with no laps, in IDLE and in RUN
    drive(1, 0, 0, 0, 30);
    drive(0, 0, 0, 1, 31);
    drive(0, 1, 0, 0, 32);
    drive(0, 0, 0, 1, 33);
    drive(0, 1, 0, 0, 34);
    drive(0, 0, 0, 1, 35);
    idle(36);

    // hard reset mid-recall, between edges
    drive(0, 1, 0, 0, 40);
    drive(0, 0, 1, 0, 7);
    drive(0, 1, 0, 0, 41);
    drive(0, 0, 0, 1, 42);
    idle(43);
    @(negedge clk);
    #2;
    hard_reset = 1'b0;
    #1;
    check_outs("async_reset", reset_e, 1'b1);
    @(negedge clk);
    check_outs("reset_hold", reset_e, 1'b1);
    hard_reset = 1'b1;
    model_reset();
    drive(0, 1, 0, 0, 50);
    idle(51);

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      drive($urandom_range(0, 39) == 0, $urandom_range(0, 7) == 0,
            $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
            CNT_W'($urandom));
    end
    idle(0);
    idle(0);

    @(posedge clk);
    #2;
    checks++;
    if (sb_q.size() == 0) passed++;
    else $display("FAIL drain: got %0d pending entries, want 0", sb_q.size());

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
